// File: rtl/multihash_encode.sv
// multihash_encode: prepends varint(codec) + varint(length) to each AXI-Stream
// packet, shifting the digest up by the header size through an 8-entry FIFO.
module multihash_encode #(
    parameter int C_AXIS_DATA_WIDTH  = 512,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready
);
    localparam int DW  = C_AXIS_DATA_WIDTH;
    localparam int DB  = DW / 8;
    localparam int TUW = C_AXIS_TUSER_WIDTH;
    localparam int VW  = $clog2(DB + 5);
    localparam logic [VW-1:0] DBV = VW'(DB);
    localparam logic [1:0] S_HEADER = 2'd0, S_SHIFT = 2'd1, S_FLUSH = 2'd2;

    logic [1:0]     state;
    logic [2:0]     h_q, h_new, h;
    logic [31:0]    carry, hdr, low;
    logic [VW-1:0]  fcnt, v, vh, n;
    logic [TUW-1:0] user_q;
    logic [13:0]    codec;
    logic [15:0]    len;
    logic [7:0]     c0, c1, l0, l1;
    logic           acc, wr, rd, nearly_full;
    logic [DW-1:0]  w_data;
    logic [DB-1:0]  w_keep;
    logic [TUW-1:0] w_user;
    logic           w_last;
    logic [3:0]     count;
    logic [2:0]     wr_ptr, rd_ptr;
    logic [DW-1:0]  mem_data [8];
    logic [DB-1:0]  mem_keep [8];
    logic [TUW-1:0] mem_user [8];
    logic           mem_last [8];

    assign codec = s_axis_tuser[45:32];
    assign len   = s_axis_tuser[15:0];
    assign c0    = {|codec[13:7], codec[6:0]};
    assign c1    = {1'b0, codec[13:7]};
    assign l0    = {|len[13:7], len[6:0]};
    assign l1    = {1'b0, len[13:7]};
    assign h_new = (|codec[13:7] ? 3'd2 : 3'd1) + (|len[13:7] ? 3'd2 : 3'd1);
    assign hdr   = |codec[13:7] ? {l1, l0, c1, c0} : {8'h00, l1, l0, c0};
    assign h     = state == S_HEADER ? h_new : h_q;
    // Low H output bytes come from the header on the first beat, the carry afterwards.
    assign low   = (state == S_HEADER ? hdr : carry) & ~(32'hffff_ffff << {h, 3'b000});

    always_comb begin
        v = '0;
        for (int i = 0; i < DB; i++) v = v + VW'(s_axis_tkeep[i]);
    end

    assign vh            = v + VW'(h);
    assign nearly_full   = count >= 4'd7;
    assign s_axis_tready = axis_resetn && !nearly_full && state != S_FLUSH;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign wr            = acc || (state == S_FLUSH && !nearly_full);
    assign rd            = m_axis_tvalid && m_axis_tready;
    assign n             = state == S_FLUSH ? fcnt : (vh > DBV ? DBV : vh);
    assign w_keep        = {DB{1'b1}} >> (DBV - n);
    assign w_data        = state == S_FLUSH ? DW'(carry) : (s_axis_tdata << {h, 3'b000}) | DW'(low);
    assign w_user        = state == S_HEADER ? {s_axis_tuser[TUW-1:16], len + 16'(h_new)} : user_q;
    assign w_last        = state == S_FLUSH || (s_axis_tlast && vh <= DBV);

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state  <= S_HEADER;
            h_q    <= '0;
            carry  <= '0;
            fcnt   <= '0;
            user_q <= '0;
        end else if (acc) begin
            carry <= 32'(s_axis_tdata >> {DBV - VW'(h), 3'b000});
            if (state == S_HEADER) begin
                h_q    <= h_new;
                user_q <= w_user;
            end
            if (!s_axis_tlast) state <= S_SHIFT;
            else if (vh > DBV) begin
                state <= S_FLUSH;
                fcnt  <= vh - DBV;
            end else state <= S_HEADER;
        end else if (state == S_FLUSH && !nearly_full) begin
            state <= S_HEADER;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count  <= count + {3'b000, wr} - {3'b000, rd};
            wr_ptr <= wr_ptr + {2'b00, wr};
            rd_ptr <= rd_ptr + {2'b00, rd};
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (wr) begin
            mem_data[wr_ptr] <= w_data;
            mem_keep[wr_ptr] <= w_keep;
            mem_user[wr_ptr] <= w_user;
            mem_last[wr_ptr] <= w_last;
        end
    end

    assign m_axis_tvalid = count != 4'd0;
    assign m_axis_tdata  = mem_data[rd_ptr];
    assign m_axis_tkeep  = mem_keep[rd_ptr];
    assign m_axis_tuser  = mem_user[rd_ptr];
    assign m_axis_tlast  = mem_last[rd_ptr];
endmodule

// File: tb/tb_multihash_encode.sv
// tb_multihash_encode: random and directed packets checked against a byte-stream
// model (header bytes ++ payload bytes, re-chunked into DATA_BYTES beats).
module tb_multihash_encode;
    localparam int DW  = 512;
    localparam int DB  = DW / 8;
    localparam int TUW = 128;

    typedef struct {
        logic [DW-1:0]  data;
        logic [DB-1:0]  keep;
        logic [TUW-1:0] user;
        logic           last;
    } beat_t;

    logic           clk = 0;
    logic           rst_n = 0;
    logic [DW-1:0]  s_axis_tdata = '0;
    logic [DB-1:0]  s_axis_tkeep = '0;
    logic [TUW-1:0] s_axis_tuser = '0;
    logic           s_axis_tvalid = 0;
    logic           s_axis_tlast = 0;
    logic           s_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic [DB-1:0]  m_axis_tkeep;
    logic [TUW-1:0] m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready = 0;

    beat_t      expq[$];
    beat_t      e;
    logic [7:0] bq[$];
    logic [DW-1:0] mask;
    int total = 0, bad = 0, tlast_seen = 0, acc_cnt = 0;
    bit stall = 1;

    multihash_encode #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TUW)) dut (
        .axis_aclk(clk), .axis_resetn(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 m_axis_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Output scoreboard and input-acceptance counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            if (expq.size() == 0) check("extra_beat", DW'(1), DW'(0));
            else begin
                e = expq.pop_front();
                for (int i = 0; i < DB; i++) mask[8*i +: 8] = {8{e.keep[i]}};
                check("tkeep", DW'(m_axis_tkeep), DW'(e.keep));
                check("tlast", DW'(m_axis_tlast), DW'(e.last));
                check("tuser", DW'(m_axis_tuser), DW'(e.user));
                check("tdata", m_axis_tdata & mask, e.data & mask);
                if (m_axis_tlast) tlast_seen++;
            end
        end
        if (rst_n && s_axis_tvalid && s_axis_tready) acc_cnt++;
    end

    function automatic logic [DB-1:0] keep_of(input int nb);
        logic [DB-1:0] ones = '1;
        return ones >> (DB - nb);
    endfunction

    function automatic void push_varint(input logic [15:0] val);
        int x = int'(val) % 16384;
        if (x < 128) bq.push_back(8'(x));
        else begin
            bq.push_back(8'(x % 128 + 128));
            bq.push_back(8'(x / 128));
        end
    endfunction

    task automatic drive_beat(input logic [DW-1:0] d, input logic [DB-1:0] k,
                              input logic [TUW-1:0] u, input logic last);
        int t = 0;
        s_axis_tdata = d;
        s_axis_tkeep = k;
        s_axis_tuser = u;
        s_axis_tlast = last;
        s_axis_tvalid = 1;
        @(negedge clk);
        while (!s_axis_tready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!s_axis_tready) check("ready_timeout", DW'(0), DW'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_packet(input logic [15:0] codec, input logic [15:0] len,
                               input int nb, input int lastv);
        logic [TUW-1:0] user, junk;
        logic [DW-1:0]  d[4];
        beat_t          x;
        int hsz, idx, nv;
        for (int i = 0; i < TUW / 32; i++) user[32*i +: 32] = $urandom;
        user[47:32] = codec;
        user[15:0]  = len;
        bq.delete();
        push_varint(codec);
        push_varint(len);
        hsz = bq.size();
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < DW / 32; i++) d[b][32*i +: 32] = $urandom;
            nv = (b < nb - 1) ? DB : lastv;
            for (int i = 0; i < nv; i++) bq.push_back(d[b][8*i +: 8]);
        end
        idx = 0;
        while (idx < bq.size()) begin
            x.data = '0;
            x.keep = '0;
            for (int i = 0; i < DB && idx < bq.size(); i++) begin
                x.data[8*i +: 8] = bq[idx];
                x.keep[i] = 1'b1;
                idx++;
            end
            x.last = (idx == bq.size());
            x.user = {user[TUW-1:16], len + 16'(hsz)};
            expq.push_back(x);
        end
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < TUW / 32; i++) junk[32*i +: 32] = $urandom;
            drive_beat(d[b], (b < nb - 1) ? keep_of(DB) : keep_of(lastv),
                       (b == 0) ? user : junk, b == nb - 1);
        end
        s_axis_tvalid = 0;
        if (lastv + hsz > DB) check("flush_ready_low", DW'(s_axis_tready), DW'(0));
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() > 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("drain", DW'(expq.size()), DW'(0));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0, a0;
        logic [DW-1:0] pd;
        logic [TUW-1:0] pu;
        #1;
        check("rst_mvalid", DW'(m_axis_tvalid), DW'(0));
        check("rst_sready", DW'(s_axis_tready), DW'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk);
        #1;
        check("post_rst_sready", DW'(s_axis_tready), DW'(1));
        check("post_rst_mvalid", DW'(m_axis_tvalid), DW'(0));
        stall = 0;

        send_packet(16'h12, 16'd32, 1, 32);
        send_packet(16'h13, 16'd64, 1, 64);
        send_packet(16'h200, 16'd200, 4, 8);
        send_packet(16'h12, 16'd32, 1, 0);
        send_packet(16'h3FFF, 16'hFFFF, 2, 63);
        drain();

        t0 = tlast_seen;
        send_packet(16'h12, 16'd32, 1, 32);
        send_packet(16'h7F, 16'd16, 1, 16);
        drain();
        check("b2b_tlast_count", DW'(tlast_seen - t0), DW'(2));

        stall = 1;
        repeat (2) @(posedge clk);
        #1 a0 = acc_cnt;
        fork
            repeat (10) send_packet(16'h12, 16'd32, 1, 32);
            begin
                repeat (20) @(posedge clk);
                #1;
                check("bp_sready_low", DW'(s_axis_tready), DW'(0));
                check("bp_accepted", DW'(acc_cnt - a0), DW'(7));
                check("bp_mvalid", DW'(m_axis_tvalid), DW'(1));
                stall = 0;
            end
        join
        drain();
        check("bp_all_accepted", DW'(acc_cnt - a0), DW'(10));

        stall = 1;
        repeat (2) @(posedge clk);
        #1;
        pu = '0;
        pu[47:32] = 16'h200;
        pu[15:0]  = 16'd200;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < DW / 32; i++) pd[32*i +: 32] = $urandom;
            drive_beat(pd, keep_of(DB), pu, 1'b0);
        end
        check("mid_mvalid_before", DW'(m_axis_tvalid), DW'(1));
        #2 rst_n = 0;
        #1;
        check("mid_rst_mvalid", DW'(m_axis_tvalid), DW'(0));
        check("mid_rst_sready", DW'(s_axis_tready), DW'(0));
        s_axis_tvalid = 0;
        @(posedge clk);
        #1 rst_n = 1;
        stall = 0;
        @(posedge clk);
        #1;
        check("mid_post_sready", DW'(s_axis_tready), DW'(1));
        send_packet(16'h12, 16'd32, 1, 32);
        drain();

        for (int p = 0; p < 40; p++) begin
            logic [15:0] c, l;
            int nb;
            case ($urandom_range(0, 2))
                0: c = 16'($urandom_range(0, 127));
                1: c = 16'($urandom_range(128, 16383));
                default: c = 16'($urandom);
            endcase
            l = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 127)) : 16'($urandom);
            nb = $urandom_range(1, 4);
            send_packet(c, l, nb, $urandom_range(0, DB));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        t0 = tlast_seen;
        drain();
        check("final_queue_empty", DW'(expq.size()), DW'(0));
        check("final_mvalid", DW'(m_axis_tvalid), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multihash_encode.md
MULTIHASH_ENCODE -- requirements
Module: multihash_encode

Interface
REQ-001 SHALL have parameter C_AXIS_DATA_WIDTH, default 512, meaning AXI-Stream data width in bits (multiple of 8, DATA_BYTES = width/8).
REQ-002 SHALL have parameter C_AXIS_TUSER_WIDTH, default 128, meaning AXI-Stream tuser width in bits (>= 48).
REQ-003 axis_aclk  input  1  single clock for all logic.
REQ-004 axis_resetn  input  1  asynchronous, active-low reset.
REQ-005 s_axis_tdata  input  C_AXIS_DATA_WIDTH  raw digest bytes, byte 0 in bits [7:0].
REQ-006 s_axis_tkeep  input  C_AXIS_DATA_WIDTH/8  contiguous low-aligned byte enables.
REQ-007 s_axis_tuser  input  C_AXIS_TUSER_WIDTH  [15:0] digest length in bytes, [47:32] multicodec code, others pass-through; sampled on the first beat only.
REQ-008 s_axis_tvalid, s_axis_tlast  input  1 each; s_axis_tready  output  1.
REQ-009 m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast  output  same widths; m_axis_tready  input  1.

Function
REQ-010 SHALL prepend a multihash header = varint(codec) followed by varint(length) to each packet and shift the digest payload up by the header size H.
REQ-011 Varint: value < 128 -> 1 byte {0,v[6:0]}; 128..16383 -> 2 bytes {1,v[6:0]}, {0,v[13:7]}; bits [15:14] ignored; H therefore in 2..4.
REQ-012 SHALL latch codec, length, H and tuser at first-beat acceptance; H is constant for the whole packet.
REQ-013 State machine HEADER (awaiting first beat), SHIFT (mid-packet), FLUSH (emit carry-over); reset state HEADER.
REQ-014 HEADER, beat accepted: output tdata = header in bytes [H-1:0], input bytes [DATA_BYTES-H-1:0] in bytes above; top H input bytes saved as carry.
REQ-015 SHIFT, beat accepted: output = carry in bytes [H-1:0] plus input bytes shifted up by H; new carry = top H input bytes.
REQ-016 Output tkeep = low min(V+H, DATA_BYTES) bits set, where V = popcount of s_axis_tkeep.
REQ-017 On the tlast beat: if V+H <= DATA_BYTES, output beat has tlast=1 and next state HEADER; else output beat tlast=0, next state FLUSH.
REQ-018 FLUSH: write one beat of the carry (V+H-DATA_BYTES valid bytes, low-aligned, tlast=1) when FIFO not nearly full, without consuming input; then HEADER.
REQ-019 Non-last beat in HEADER -> SHIFT; non-last in SHIFT -> SHIFT.
REQ-020 Output tuser = latched tuser with [15:0] replaced by length+H (total multihash bytes), identical on every beat of the packet.
REQ-021 Output SHALL pass through an 8-entry fall-through FIFO; nearly_full asserted at >= 7 entries; m_axis_tvalid = FIFO not empty.
REQ-022 s_axis_tready = !nearly_full AND state != FLUSH; input accepted only on tvalid & tready.
REQ-023 Latency: accepted beat visible on m_axis one cycle after acceptance if FIFO was empty.
REQ-024 tkeep all-zero on a single-beat packet SHALL emit a header-only beat (tkeep low H bits, tlast=1).
REQ-025 Length field is not checked against received bytes; mismatches pass through unflagged.

Reset
REQ-026 Reset assertion SHALL immediately force state HEADER, clear carry, empty FIFO; m_axis_tvalid=0, s_axis_tready=0 while reset held.
REQ-027 After deassertion s_axis_tready=1 from the first clock edge; a packet interrupted by reset is discarded, no partial tlast emitted.
REQ-028 m_axis_tdata/tkeep/tuser/tlast are don't-care while m_axis_tvalid=0.

Verification
REQ-029 codec 0x12, len 32, one beat tkeep=32 ones -> one beat, bytes 0..1 = 12 20, bytes 2..33 = digest, tkeep 34 ones, tlast, tuser[15:0]=34.
REQ-030 codec 0x13, len 64, one full 64-byte beat (512-bit) -> beat 1 tkeep all ones tlast=0, then FLUSH beat with 2 bytes (digest 62,63), tkeep 0x3, tlast=1; s_axis_tready low during FLUSH.
REQ-031 codec 0x200, len 200, four beats (64,64,64,8 bytes) -> header 80 04 C8 01 (H=4), outputs 64,64,64,12 bytes, tlast on 4th, tuser[15:0]=204.
REQ-032 m_axis_tready=0 for 20 cycles with continuous input -> s_axis_tready drops after 7 writes, no beat lost or duplicated after release.
REQ-033 axis_resetn pulsed low mid-packet (after beat 2 of REQ-031) -> m_axis_tvalid=0 at once; following packet per REQ-029 encoded correctly.
REQ-034 Back-to-back packets with no idle cycle, second codec 0x7F len 16 -> headers 12 20 then 7F 10, tlast count equals packet count.
